// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester port bundle between a data-memory master and dmem_arbiter
interface dmem_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata, err);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data-memory arbiter with address filtering and registered response
// Optional DMEM_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority with starvation guard.
module dmem_arbiter #(
    parameter int DATA_MEM_DEPTH = 256,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic              clk,
    input  logic              rst,
    dmem_arbiter_if.slave     m0,
    dmem_arbiter_if.slave     m1,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    function automatic logic addr_legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ({2'b00, a[31:2]} < 32'(DATA_MEM_DEPTH));
    endfunction

    logic        gnt0;
    logic        gnt1;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    // last_grant: 0 = m0 was granted last, 1 = m1 was granted last
    logic        last_grant;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (m0.req && m1.req) begin
                gnt0 = last_grant;
                gnt1 = !last_grant;
            end else begin
                gnt0 = m0.req;
                gnt1 = m1.req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= 1'b1;
        else if (gnt0)
            last_grant <= 1'b0;
        else if (gnt1)
            last_grant <= 1'b1;
    end
`else
    logic [3:0]  starve_cnt;
    logic        m1_starved;

    assign m1_starved = (starve_cnt >= 4'(STARVE_LIMIT));

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (m0.req && m1.req) begin
                gnt0 = !m1_starved;
                gnt1 = m1_starved;
            end else begin
                gnt0 = m0.req;
                gnt1 = m1.req;
            end
        end
    end

    // Never exceeds STARVE_LIMIT: reaching it forces the m1 grant that clears it
    always_ff @(posedge clk) begin
        if (rst || !m1.req || gnt1)
            starve_cnt <= 4'd0;
        else
            starve_cnt <= starve_cnt + 4'd1;
    end
`endif

    logic        any_gnt;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_legal;

    assign any_gnt   = gnt0 || gnt1;
    assign sel_we    = gnt1 ? m1.we    : m0.we;
    assign sel_addr  = gnt1 ? m1.addr  : m0.addr;
    assign sel_wdata = gnt1 ? m1.wdata : m0.wdata;
    assign sel_legal = addr_legal(sel_addr);

    // Illegal accesses never reach the array: enables and bus stay at idle values
    always_comb begin
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        mem_addr     = 32'd0;
        mem_wdata    = 32'd0;
        if (any_gnt && sel_legal) begin
            mem_addr = sel_addr;
            if (sel_we) begin
                mem_write_en = 1'b1;
                mem_wdata    = sel_wdata;
            end else begin
                mem_read_en  = 1'b1;
            end
        end
    end

    logic        resp_valid;
    logic        resp_id;
    logic        resp_err;
    logic [31:0] resp_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_err   <= 1'b0;
            resp_data  <= 32'd0;
        end else begin
            resp_valid <= any_gnt;
            resp_id    <= gnt1;
            resp_err   <= any_gnt && !sel_legal;
            resp_data  <= (any_gnt && sel_legal && !sel_we) ? mem_rdata : 32'd0;
        end
    end

    // Masking with rst drops a response registered just before reset is raised
    logic        rv0;
    logic        rv1;

    assign rv0 = resp_valid && !resp_id && !rst;
    assign rv1 = resp_valid &&  resp_id && !rst;

    assign m0.gnt    = gnt0;
    assign m0.rvalid = rv0;
    assign m0.err    = rv0 && resp_err;
    assign m0.rdata  = rv0 ? resp_data : 32'd0;

    assign m1.gnt    = gnt1;
    assign m1.rvalid = rv1;
    assign m1.err    = rv1 && resp_err;
    assign m1.rdata  = rv1 ? resp_data : 32'd0;

endmodule
